// File: rtl/key_pkg.sv
// Shared definitions for the key register bank: key geometry and the load state encoding.
package key_pkg;

  localparam int KEY_WORD_W    = 32;
  localparam int KEY_NUM_WORDS = 4;
  localparam int KEY_W         = KEY_WORD_W * KEY_NUM_WORDS;
  localparam int KEY_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } key_load_state_t;

endpackage

// File: rtl/key_register_bank_if.sv
// Key configuration bus between the word source (master) and the key register bank (slave).
interface key_register_bank_if import key_pkg::*; #(
  parameter int WORD_W    = KEY_WORD_W,
  parameter int NUM_WORDS = KEY_NUM_WORDS
) ();

  logic                        key_config;
  logic                        in_valid;
  logic [WORD_W-1:0]           key_word_in;
  logic                        key_clear;
  logic [NUM_WORDS*WORD_W-1:0] key_out;
  logic                        key_ready;
  logic [KEY_IDX_W-1:0]        word_index;
  logic                        key_error;

  modport master (
    output key_config,
    output in_valid,
    output key_word_in,
    output key_clear,
    input  key_out,
    input  key_ready,
    input  word_index,
    input  key_error
  );

  modport slave (
    input  key_config,
    input  in_valid,
    input  key_word_in,
    input  key_clear,
    output key_out,
    output key_ready,
    output word_index,
    output key_error
  );

endinterface

// File: rtl/key_register_bank.sv
// Collects four key words during a key_config window and holds the assembled
// 128-bit key, flagging it ready until the next load or a clear.
module key_register_bank import key_pkg::*; #(
  parameter int WORD_W    = KEY_WORD_W,
  parameter int NUM_WORDS = KEY_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  key_register_bank_if.slave bus
);

  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_WORDS - 1);

  key_load_state_t      state_q, state_d;
  logic [KEY_IDX_W-1:0] word_index_q, word_index_d;
  logic [WORD_W-1:0]    key_reg_q [NUM_WORDS];
  logic [WORD_W-1:0]    key_reg_d [NUM_WORDS];
  logic                 key_ready_q, key_ready_d;
  logic                 key_error_q, key_error_d;
  logic [NUM_WORDS*WORD_W-1:0] key_out_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_index_q <= '0;
      key_reg_q    <= '{default: '0};
      key_ready_q  <= 1'b0;
      key_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_index_q <= word_index_d;
      key_reg_q    <= key_reg_d;
      key_ready_q  <= key_ready_d;
      key_error_q  <= key_error_d;
    end
  end

  // key_clear overrides any word or config activity in the same cycle
  always_comb begin
    state_d      = state_q;
    word_index_d = word_index_q;
    key_reg_d    = key_reg_q;
    key_ready_d  = key_ready_q;
    key_error_d  = 1'b0;

    if (bus.key_clear) begin
      state_d      = IDLE;
      word_index_d = '0;
      key_reg_d    = '{default: '0};
      key_ready_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          word_index_d = '0;
          if (bus.key_config && bus.in_valid) begin
            key_reg_d[0] = bus.key_word_in;
            word_index_d = KEY_IDX_W'(1);
            key_ready_d  = 1'b0;
            state_d      = LOAD;
          end
        end

        LOAD: begin
          // A config drop aborts even if a word arrives on the same edge
          if (!bus.key_config) begin
            state_d      = IDLE;
            word_index_d = '0;
            key_error_d  = 1'b1;
          end else if (bus.in_valid) begin
            key_reg_d[word_index_q] = bus.key_word_in;
            if (word_index_q == LAST_IDX) begin
              word_index_d = '0;
              key_ready_d  = 1'b1;
              state_d      = READY;
            end else begin
              word_index_d = word_index_q + KEY_IDX_W'(1);
            end
          end
        end

        READY: begin
          if (!bus.key_config) begin
            state_d = IDLE;
          end else if (bus.in_valid) begin
            key_error_d = 1'b1;
          end
        end

        default: begin
          state_d      = IDLE;
          word_index_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_out_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      key_out_flat[i*WORD_W +: WORD_W] = key_reg_q[i];
    end
  end

  assign bus.key_out    = key_out_flat;
  assign bus.key_ready  = key_ready_q;
  assign bus.word_index = word_index_q;
  assign bus.key_error  = key_error_q;

endmodule

// File: tb/tb_key_register_bank.sv
// Directed self-checking bench for key_register_bank with hand-computed expectations.
module tb_key_register_bank;
  import key_pkg::*;

  localparam logic [KEY_W-1:0] KEY_A = 128'h44444444_33333333_22222222_11111111;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  key_register_bank_if bus ();

  key_register_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [KEY_WORD_W-1:0] w);
    bus.in_valid    = 1'b1;
    bus.key_word_in = w;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.key_config  = 1'b0;
    bus.in_valid    = 1'b0;
    bus.key_word_in = '0;
    bus.key_clear   = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.key_out !== '0) $display("[TB] FAIL reset_key_out: got %h expected 0", bus.key_out);
    else passed++;
    checks++;
    if (bus.key_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", bus.key_ready);
    else passed++;
    checks++;
    if (bus.word_index !== 2'd0) $display("[TB] FAIL reset_index: got %0d expected 0", bus.word_index);
    else passed++;
    checks++;
    if (bus.key_error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", bus.key_error);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_idx;
    bus.key_config = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(32'h11111111 * (i + 1));
      exp_idx = 2'((i + 1) % 4);
      checks++;
      if (bus.word_index !== exp_idx)
        $display("[TB] FAIL b2b_index_%0d: got %0d expected %0d", i, bus.word_index, exp_idx);
      else passed++;
      checks++;
      if (bus.key_ready !== (i == 3))
        $display("[TB] FAIL b2b_ready_%0d: got %b expected %b", i, bus.key_ready, (i == 3));
      else passed++;
    end
    checks++;
    if (bus.key_out !== KEY_A) $display("[TB] FAIL b2b_key_out: got %h expected %h", bus.key_out, KEY_A);
    else passed++;
  endtask

  task automatic test_overrun();
    send_word(32'hDEADBEEF);
    checks++;
    if (bus.key_error !== 1'b1) $display("[TB] FAIL overrun_error: got %b expected 1", bus.key_error);
    else passed++;
    checks++;
    if (bus.key_out !== KEY_A) $display("[TB] FAIL overrun_key_out: got %h expected %h", bus.key_out, KEY_A);
    else passed++;
    checks++;
    if (bus.key_ready !== 1'b1) $display("[TB] FAIL overrun_ready: got %b expected 1", bus.key_ready);
    else passed++;
    tick();
    checks++;
    if (bus.key_error !== 1'b0) $display("[TB] FAIL overrun_error_len: got %b expected 0", bus.key_error);
    else passed++;
  endtask

  task automatic test_ready_exit();
    bus.key_config = 1'b0;
    tick();
    send_word(32'hCAFEF00D);
    checks++;
    if (bus.key_ready !== 1'b1) $display("[TB] FAIL exit_ready: got %b expected 1", bus.key_ready);
    else passed++;
    checks++;
    if (bus.key_out !== KEY_A) $display("[TB] FAIL exit_key_out: got %h expected %h", bus.key_out, KEY_A);
    else passed++;
    checks++;
    if (bus.key_error !== 1'b0 || bus.word_index !== 2'd0)
      $display("[TB] FAIL exit_ignored_word: got err=%b idx=%0d expected err=0 idx=0", bus.key_error, bus.word_index);
    else passed++;
  endtask

  task automatic test_abort();
    logic [KEY_W-1:0] exp_key;
    exp_key = 128'h44444444_33333333_BBBBBBBB_AAAAAAAA;
    bus.key_config = 1'b1;
    send_word(32'hAAAAAAAA);
    checks++;
    if (bus.key_ready !== 1'b0) $display("[TB] FAIL abort_ready_drop: got %b expected 0", bus.key_ready);
    else passed++;
    send_word(32'hBBBBBBBB);
    bus.key_config = 1'b0;
    tick();
    checks++;
    if (bus.key_error !== 1'b1) $display("[TB] FAIL abort_error: got %b expected 1", bus.key_error);
    else passed++;
    checks++;
    if (bus.word_index !== 2'd0 || bus.key_ready !== 1'b0)
      $display("[TB] FAIL abort_state: got idx=%0d ready=%b expected idx=0 ready=0", bus.word_index, bus.key_ready);
    else passed++;
    checks++;
    if (bus.key_out !== exp_key) $display("[TB] FAIL abort_partial: got %h expected %h", bus.key_out, exp_key);
    else passed++;
    tick();
    checks++;
    if (bus.key_error !== 1'b0) $display("[TB] FAIL abort_error_len: got %b expected 0", bus.key_error);
    else passed++;
  endtask

  task automatic test_clear();
    bus.key_config = 1'b1;
    for (int i = 0; i < 4; i++) send_word(32'h11111111 * (i + 1));
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    checks++;
    if (bus.key_out !== '0 || bus.key_ready !== 1'b0)
      $display("[TB] FAIL clear_key: got key=%h ready=%b expected 0/0", bus.key_out, bus.key_ready);
    else passed++;
    checks++;
    if (bus.key_error !== 1'b0) $display("[TB] FAIL clear_no_error: got %b expected 0", bus.key_error);
    else passed++;
  endtask

  task automatic test_clear_with_4th();
    for (int i = 0; i < 3; i++) send_word(32'h11111111 * (i + 1));
    bus.key_clear = 1'b1;
    send_word(32'h44444444);
    bus.key_clear = 1'b0;
    checks++;
    if (bus.key_ready !== 1'b0 || bus.key_out !== '0)
      $display("[TB] FAIL clear_4th: got ready=%b key=%h expected 0/0", bus.key_ready, bus.key_out);
    else passed++;
    checks++;
    if (bus.word_index !== 2'd0) $display("[TB] FAIL clear_4th_index: got %0d expected 0", bus.word_index);
    else passed++;
  endtask

  task automatic test_abort_on_4th();
    logic [KEY_W-1:0] exp_key;
    exp_key = 128'h00000000_33333333_22222222_11111111;
    for (int i = 0; i < 3; i++) send_word(32'h11111111 * (i + 1));
    bus.key_config = 1'b0;
    send_word(32'h44444444);
    checks++;
    if (bus.key_error !== 1'b1 || bus.key_ready !== 1'b0)
      $display("[TB] FAIL abort_4th_flags: got err=%b ready=%b expected 1/0", bus.key_error, bus.key_ready);
    else passed++;
    checks++;
    if (bus.key_out !== exp_key) $display("[TB] FAIL abort_4th_key: got %h expected %h", bus.key_out, exp_key);
    else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    bus.key_config = 1'b1;
    for (int i = 0; i < 3; i++) send_word(32'h11111111 * (i + 1));
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.key_out !== '0 || bus.key_ready !== 1'b0 || bus.word_index !== 2'd0 || bus.key_error !== 1'b0)
      $display("[TB] FAIL async_reset: got key=%h ready=%b idx=%0d err=%b expected all 0",
               bus.key_out, bus.key_ready, bus.word_index, bus.key_error);
    else passed++;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gapped();
    bus.key_config = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.key_ready !== 1'b0) $display("[TB] FAIL gap_ready_early_%0d: got %b expected 0", i, bus.key_ready);
      else passed++;
      send_word(32'h11111111 * (i + 1));
      tick();
      tick();
    end
    checks++;
    if (bus.key_ready !== 1'b1) $display("[TB] FAIL gap_ready: got %b expected 1", bus.key_ready);
    else passed++;
    checks++;
    if (bus.key_out !== KEY_A) $display("[TB] FAIL gap_key_out: got %h expected %h", bus.key_out, KEY_A);
    else passed++;
    bus.key_config = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_back_to_back();
    test_overrun();
    test_ready_exit();
    test_abort();
    test_clear();
    test_clear_with_4th();
    test_abort_on_4th();
    test_async_reset();
    test_gapped();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
